// File: rtl/alu_ctrl_queue.sv
// Purpose : decode ALUOp + opcode[31:21] into the 4-bit ALU operation code and queue it for execute.
// Latency : 1 cycle from an accepted push to the head output when the queue was empty; 1 entry/cycle sustained.
// Backpressure: in_ready depends on registered occupancy only; a pop while full frees a slot for the next cycle.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready               decode-side handshake; in_opcode[10:0], in_aluop[1:0] are decoded on push
//   flush                           drops every buffered entry; in_valid/out_ready ignored in that cycle
//   out_valid/out_ready             execute-side handshake; out_alu_ctrl/out_illegal carry the head entry
//   illegal_count[CNT_W-1:0]        saturating count of accepted illegal encodings (reset-only clear)
module alu_ctrl_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_opcode,
  input  logic [1:0]       in_aluop,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       illegal;
    logic [3:0] code;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Decode of the offered entry; only the stored result is ever issued.
  always_comb begin
    dec.code    = 4'b0000;
    dec.illegal = 1'b0;
    case (in_aluop)
      2'b00: dec.code = 4'b0010;
      2'b01: dec.code = 4'b0111;
      2'b10: begin
        case (in_opcode)
          11'b10001011000: dec.code = 4'b0010;
          11'b11001011000: dec.code = 4'b0110;
          11'b10001010000: dec.code = 4'b0000;
          11'b10101010000: dec.code = 4'b0001;
          11'b11101010000: dec.code = 4'b1100;
          default:         dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign head         = mem[rd_ptr];
  assign out_alu_ctrl = out_valid ? head.code : 4'b0000;
  assign out_illegal  = out_valid ? head.illegal : 1'b0;

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // push already excludes the flush cycle, so a flushed illegal offer is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (push && dec.illegal && (illegal_count != '1)) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_queue.sv
// Purpose : directed check of decode, ordering, backpressure, flush, reset and counter saturation.
// Latency : inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Backpressure: driven directly through out_ready.
module tb_alu_ctrl_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_opcode;
  logic [1:0]  in_aluop;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  // Second instance with a 2-bit counter to reach saturation quickly.
  logic        d2_in_valid;
  logic        d2_in_ready;
  logic [1:0]  d2_in_aluop;
  logic        d2_out_valid;
  logic [3:0]  d2_out_alu_ctrl;
  logic        d2_out_illegal;
  logic [1:0]  d2_illegal_count;

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_NOR = 11'b11101010000;

  alu_ctrl_queue #(.DEPTH(2), .CNT_W(8)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_aluop      (in_aluop),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count)
  );

  alu_ctrl_queue #(.DEPTH(2), .CNT_W(2)) u_dut_sat (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (d2_in_valid),
    .in_ready      (d2_in_ready),
    .in_opcode     (11'b0),
    .in_aluop      (d2_in_aluop),
    .flush         (1'b0),
    .out_valid     (d2_out_valid),
    .out_ready     (1'b1),
    .out_alu_ctrl  (d2_out_alu_ctrl),
    .out_illegal   (d2_out_illegal),
    .illegal_count (d2_illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [1:0] op, input logic [10:0] opc);
    in_valid  = v;
    in_aluop  = op;
    in_opcode = opc;
  endtask

  logic [1:0]  sw_op  [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [10:0] sw_opc [7] = '{11'h7ff, 11'h000, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_NOR};
  logic [3:0]  sw_exp [7] = '{4'b0010, 4'b0111, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100};

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 2'b00, 11'b0);
    d2_in_valid = 1'b0; d2_in_aluop = 2'b11;

    // Reset held two cycles, then idle.
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_alu_ctrl",  32'(out_alu_ctrl), 0);
    chk("rst_illegal",   32'(out_illegal), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_ill_cnt",   32'(illegal_count), 0);

    // Decode sweep with a consumer that is always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      offer(1'b1, sw_op[i], sw_opc[i]);
      step();
      chk($sformatf("sweep%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("sweep%0d_code", i),  32'(out_alu_ctrl), 32'(sw_exp[i]));
      chk($sformatf("sweep%0d_ill", i),   32'(out_illegal), 0);
    end
    offer(1'b0, 2'b00, 11'b0);
    step();
    chk("sweep_drain_valid", 32'(out_valid), 0);

    // Backpressure: fill with SUB, ORR; AND is held off while full.
    out_ready = 1'b0;
    offer(1'b1, 2'b10, OP_SUB);
    step();
    chk("bp_in_ready_1", 32'(in_ready), 1);
    offer(1'b1, 2'b10, OP_ORR);
    step();
    chk("bp_in_ready_full", 32'(in_ready), 0);
    offer(1'b1, 2'b10, OP_AND);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d_code", i),  32'(out_alu_ctrl), 32'h6);
      chk($sformatf("bp_hold%0d_ready", i), 32'(in_ready), 0);
    end
    // Pop while full: no push this edge, slot frees for the next cycle.
    out_ready = 1'b1;
    step();
    chk("bp_pop1_code",  32'(out_alu_ctrl), 32'h1);
    chk("bp_pop1_ready", 32'(in_ready), 1);
    step();
    chk("bp_pop2_code",  32'(out_alu_ctrl), 32'h0);
    chk("bp_pop2_ill",   32'(out_illegal), 0);
    chk("bp_pop2_valid", 32'(out_valid), 1);
    offer(1'b0, 2'b00, 11'b0);
    step();
    chk("bp_empty", 32'(out_valid), 0);

    // Illegal encodings.
    out_ready = 1'b0;
    offer(1'b1, 2'b11, 11'h000);
    step();
    chk("ill1_code", 32'(out_alu_ctrl), 0);
    chk("ill1_flag", 32'(out_illegal), 1);
    chk("ill1_cnt",  32'(illegal_count), 1);
    offer(1'b1, 2'b10, 11'b11111111111);
    step();
    chk("ill2_cnt",   32'(illegal_count), 2);
    chk("ill2_ready", 32'(in_ready), 0);
    offer(1'b0, 2'b00, 11'b0);
    out_ready = 1'b1;
    step();
    chk("ill2_code", 32'(out_alu_ctrl), 0);
    chk("ill2_flag", 32'(out_illegal), 1);
    step();
    chk("ill_drain", 32'(out_valid), 0);

    // Flush with two entries queued and an illegal offer in the flush cycle.
    out_ready = 1'b0;
    offer(1'b1, 2'b10, OP_ADD);
    step();
    offer(1'b1, 2'b10, OP_NOR);
    step();
    chk("fl_pre_full", 32'(in_ready), 0);
    flush = 1'b1; out_ready = 1'b1;
    offer(1'b1, 2'b11, 11'h000);
    step();
    flush = 1'b0;
    offer(1'b0, 2'b00, 11'b0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready), 1);
    chk("fl_code",  32'(out_alu_ctrl), 0);
    chk("fl_cnt",   32'(illegal_count), 2);
    // Queue works normally after a flush.
    out_ready = 1'b0;
    offer(1'b1, 2'b10, OP_ORR);
    step();
    offer(1'b0, 2'b00, 11'b0);
    chk("fl_after_code", 32'(out_alu_ctrl), 32'h1);

    // Reset mid-operation loses the entry and clears the counter.
    reset = 1'b1;
    offer(1'b1, 2'b11, 11'h000);
    step();
    reset = 1'b0;
    offer(1'b0, 2'b00, 11'b0);
    chk("rst2_valid", 32'(out_valid), 0);
    chk("rst2_cnt",   32'(illegal_count), 0);
    chk("rst2_ready", 32'(in_ready), 1);

    // Saturation on the 2-bit counter instance.
    d2_in_valid = 1'b1;
    d2_in_aluop = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat%0d_cnt", i), 32'(d2_illegal_count), (i < 3) ? (i + 1) : 3);
    end
    d2_in_valid = 1'b0;
    chk("sat_head_ill", 32'(d2_out_illegal), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_queue.md
Name: alu_ctrl_queue

Overview:
- Producer side of the 4-bit ALU operation-select interface used by the datapath's 64-bit ALU.
- Decodes the main-control ALUOp field and the instruction opcode field into the ALU operation code.
- Decoded entries are buffered in a small FIFO with valid/ready handshakes on both sides, between the decode stage and the execute stage.
- Also flags and counts illegal encodings, and supports a pipeline flush.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, at least 2.
- CNT_W, 8, width of the saturating illegal-encoding counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decode stage offers an entry.
- in_ready  output  1  queue can accept an entry.
- in_opcode  input  11  instruction bits [31:21].
- in_aluop  input  2  ALUOp from main control.
- flush  input  1  discard all buffered entries.
- out_valid  output  1  head entry available to execute stage.
- out_ready  input  1  execute stage consumes head entry.
- out_alu_ctrl  output  4  ALU operation code of head entry.
- out_illegal  output  1  head entry was an illegal encoding.
- illegal_count  output  CNT_W  saturating count of accepted illegal entries.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on reset.
- Reset: clears the FIFO (count 0, read pointer 0, write pointer 0) and sets illegal_count = 0. After reset, out_valid = 0, out_alu_ctrl = 4'b0000, out_illegal = 0, in_ready = 1.
- Decode of accepted entries (combinational on the inputs; the result is written into the FIFO):
  - aluop 00 -> 0010 (add; load/store address).
  - aluop 01 -> 0111 (pass b; CBZ).
  - aluop 10, opcode 10001011000 -> 0010 (ADD).
  - aluop 10, opcode 11001011000 -> 0110 (SUB).
  - aluop 10, opcode 10001010000 -> 0000 (AND).
  - aluop 10, opcode 10101010000 -> 0001 (ORR).
  - aluop 10, opcode 11101010000 -> 1100 (NOR).
  - aluop 10 with any other opcode, or aluop 11 -> code 0000 and illegal = 1.
  - All legal encodings have illegal = 0.
- Push: occurs when in_valid && in_ready && !flush.
- Pop: occurs when out_valid && out_ready && !flush.
- in_ready = (count != DEPTH).
  - in_ready is a function of registered state only; there is no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
  - out_alu_ctrl and out_illegal show the head entry when count != 0.
  - They are forced to 0000 and 0 when empty.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 if the FIFO was empty. Throughput is one entry per cycle when the consumer is always ready.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, both pointers advance, and order is preserved.
- Push and pop with count 0: only the push occurs. There is no bypass, because out_valid is 0.
- Pointers wrap modulo DEPTH.
- Head output must remain stable while out_valid && !out_ready. It changes only after a pop, a flush or a reset.
- Flush:
  - Next cycle, count = 0 and both pointers = 0.
  - in_valid is ignored in the flush cycle; no push occurs and illegal_count does not increment.
  - out_ready is ignored in the flush cycle.
  - illegal_count itself is not cleared by flush.
- illegal_count:
  - Increments by 1 on each push of an illegal entry.
  - Saturates at all-ones (255 with default CNT_W); it does not wrap.
  - Cleared only by reset.
- Reset mid-operation: reset has priority over flush, push and pop. All buffered entries are lost.
- An entry held in the FIFO is never re-decoded; the stored code is what is issued.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> out_valid=0, out_alu_ctrl=0000, in_ready=1, illegal_count=0.
- Decode sweep, out_ready=1: push in consecutive cycles (00,x), (01,x), (10,10001011000), (10,11001011000), (10,10001010000), (10,10101010000), (10,11101010000) -> outputs one cycle later: 0010, 0111, 0010, 0110, 0000, 0001, 1100, each with out_illegal=0.
- Backpressure, DEPTH=2, out_ready=0: push SUB then ORR.
  - in_ready drops to 0 after the 2nd push; a 3rd offer (AND) is held off.
  - Head stays 0110 for 5 cycles.
  - Raise out_ready -> 0110, then 0001, then AND (0000) in order.
- Full with pop: at count=2, assert out_ready and in_valid together -> the pop happens, no push that cycle; in_ready=1 the following cycle.
- Illegal handling: push (11,x) and (10,11111111111) -> out_alu_ctrl=0000, out_illegal=1, illegal_count=2. With CNT_W=2, push 5 illegal entries -> count saturates at 3.
- Flush: with 2 entries queued, assert flush together with in_valid carrying an illegal encoding -> next cycle out_valid=0 and in_ready=1; illegal_count is unchanged.
